// File: rtl/udp_payload_gen_pkg.sv
// rtl/udp_payload_gen_pkg.sv - shared constants, state enum and keep helper for the UDP payload generator
package udpgen_pkg;

  localparam int BEAT_BYTES = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_GAP
  } state_t;

  // Byte-enable mask for the final beat: a zero remainder means a full beat.
  function automatic logic [BEAT_BYTES-1:0] keep_mask(input logic [5:0] len_lsb);
    if (len_lsb == 6'd0) begin
      return '1;
    end
    return (64'd1 << len_lsb) - 64'd1;
  endfunction

endpackage

// File: rtl/udp_payload_gen_if.sv
// rtl/udp_payload_gen_if.sv - length and payload streams between the generator and the UDP formatter
interface udp_payload_gen_if;

  logic [15:0]                          AXIS_LEN_TDATA;
  logic                                 AXIS_LEN_TVALID;
  logic                                 AXIS_LEN_TREADY;
  logic [8*udpgen_pkg::BEAT_BYTES-1:0]  AXIS_TX_TDATA;
  logic [udpgen_pkg::BEAT_BYTES-1:0]    AXIS_TX_TKEEP;
  logic                                 AXIS_TX_TVALID;
  logic                                 AXIS_TX_TLAST;
  logic                                 AXIS_TX_TREADY;

  modport master (
    output AXIS_LEN_TDATA, AXIS_LEN_TVALID,
    input  AXIS_LEN_TREADY,
    output AXIS_TX_TDATA, AXIS_TX_TKEEP, AXIS_TX_TVALID, AXIS_TX_TLAST,
    input  AXIS_TX_TREADY
  );

  modport slave (
    input  AXIS_LEN_TDATA, AXIS_LEN_TVALID,
    output AXIS_LEN_TREADY,
    input  AXIS_TX_TDATA, AXIS_TX_TKEEP, AXIS_TX_TVALID, AXIS_TX_TLAST,
    output AXIS_TX_TREADY
  );

endinterface

// File: rtl/udp_payload_gen.sv
// rtl/udp_payload_gen.sv - emits a length word then sequence-stamped 512-bit payload beats per packet
module udp_payload_gen
  import udpgen_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 8972,
  parameter logic [7:0]  FILL_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [15:0]        payload_len,
  input  logic [31:0]        packet_count,
  input  logic [15:0]        gap_cycles,
  output logic               busy,
  output logic               len_error,
  output logic [31:0]        packets_sent,
  udp_payload_gen_if.master  axis
);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] count_q, count_d;
  logic [15:0] gap_q, gap_d;
  logic [16:0] last_beat_q, last_beat_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [63:0] seq_q, seq_d;
  logic [31:0] pkts_q, pkts_d;
  logic        len_error_q, len_error_d;
  logic        stop_pend_q, stop_pend_d;
  logic        len_valid_q, len_valid_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;

  logic        len_hs, tx_hs, at_last, len_ok, stop_now;
  logic [16:0] nbeats;
  logic [8*BEAT_BYTES-1:0] tx_data;

  assign len_hs   = len_valid_q & axis.AXIS_LEN_TREADY;
  assign tx_hs    = tx_valid_q & axis.AXIS_TX_TREADY;
  assign at_last  = (17'(beat_q) == last_beat_q);
  assign nbeats   = (17'(payload_len) + 17'd63) >> 6;
  assign len_ok   = (payload_len != 16'd0) && (32'(payload_len) <= MAX_LEN);
  assign stop_now = stop_pend_q | stop;

  // Beat payload is derived from held registers, so it is stable across stalls.
  always_comb begin
    tx_data        = {BEAT_BYTES{FILL_BYTE}};
    tx_data[63:0]  = seq_q;
    tx_data[79:64] = beat_q;
  end

  assign axis.AXIS_LEN_TDATA  = len_q;
  assign axis.AXIS_LEN_TVALID = len_valid_q;
  assign axis.AXIS_TX_TDATA   = tx_data;
  assign axis.AXIS_TX_TKEEP   = at_last ? keep_mask(len_q[5:0]) : '1;
  assign axis.AXIS_TX_TVALID  = tx_valid_q;
  assign axis.AXIS_TX_TLAST   = tx_valid_q & at_last;
  assign busy                 = busy_q;
  assign len_error            = len_error_q;
  assign packets_sent         = pkts_q;

  // Next-state logic: run control, packet sequencing and stop latching at packet boundaries.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    gap_d       = gap_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    gap_cnt_d   = gap_cnt_q;
    seq_d       = seq_q;
    pkts_d      = pkts_q;
    len_error_d = len_error_q;
    stop_pend_d = stop_pend_q;
    len_valid_d = len_valid_q;
    tx_valid_d  = tx_valid_q;

    if (stop && state_q != ST_IDLE) stop_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d       = payload_len;
            count_d     = packet_count;
            gap_d       = gap_cycles;
            last_beat_d = nbeats - 17'd1;
            seq_d       = 64'd0;
            pkts_d      = 32'd0;
            len_error_d = 1'b0;
            stop_pend_d = 1'b0;
            len_valid_d = 1'b1;
            state_d     = ST_LEN;
          end else begin
            len_error_d = 1'b1;
          end
        end
      end
      ST_LEN: begin
        if (len_hs) begin
          len_valid_d = 1'b0;
          tx_valid_d  = 1'b1;
          beat_d      = 16'd0;
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_hs) begin
          if (at_last) begin
            seq_d      = seq_q + 64'd1;
            pkts_d     = pkts_q + 32'd1;
            tx_valid_d = 1'b0;
            if (stop_now || (count_q != 32'd0 && pkts_q + 32'd1 == count_q)) begin
              stop_pend_d = 1'b0;
              state_d     = ST_IDLE;
            end else if (gap_q != 16'd0) begin
              gap_cnt_d = gap_q - 16'd1;
              state_d   = ST_GAP;
            end else begin
              len_valid_d = 1'b1;
              state_d     = ST_LEN;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 16'd0) begin
          if (stop_now) begin
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            len_valid_d = 1'b1;
            state_d     = ST_LEN;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any packet in flight immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'd0;
      count_q     <= 32'd0;
      gap_q       <= 16'd0;
      last_beat_q <= 17'd0;
      beat_q      <= 16'd0;
      gap_cnt_q   <= 16'd0;
      seq_q       <= 64'd0;
      pkts_q      <= 32'd0;
      len_error_q <= 1'b0;
      stop_pend_q <= 1'b0;
      len_valid_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_q       <= seq_d;
      pkts_q      <= pkts_d;
      len_error_q <= len_error_d;
      stop_pend_q <= stop_pend_d;
      len_valid_q <= len_valid_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_udp_payload_gen.sv
// tb/tb_udp_payload_gen.sv - scoreboard bench for udp_payload_gen
module tb_udp_payload_gen;

  typedef struct {
    logic [63:0] seq;
    logic [15:0] idx;
    logic [63:0] keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] payload_len = 16'd0;
  logic [31:0] packet_count = 32'd0;
  logic [15:0] gap_cycles = 16'd0;
  logic        busy;
  logic        len_error;
  logic [31:0] packets_sent;

  udp_payload_gen_if axis_if();

  udp_payload_gen #(.MAX_LEN(8972), .FILL_BYTE(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .payload_len  (payload_len),
    .packet_count (packet_count),
    .gap_cycles   (gap_cycles),
    .busy         (busy),
    .len_error    (len_error),
    .packets_sent (packets_sent),
    .axis         (axis_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  logic [15:0] exp_len[$];
  beat_t       exp_tx[$];
  int          dist_q[$];
  bit          have_last = 1'b0;
  int          last_cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      axis_if.AXIS_LEN_TREADY = 1'($urandom_range(0, 1));
      axis_if.AXIS_TX_TREADY  = 1'($urandom_range(0, 1));
    end else begin
      axis_if.AXIS_LEN_TREADY = 1'b1;
      axis_if.AXIS_TX_TREADY  = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no/extra event expected a matching event", name);
  endtask

  task automatic push_beat(input logic [63:0] s, input logic [15:0] i, input logic [63:0] k, input logic l);
    beat_t b;
    b.seq = s; b.idx = i; b.keep = k; b.last = l;
    exp_tx.push_back(b);
  endtask

  task automatic start_run(input logic [15:0] l, input logic [31:0] c, input logic [15:0] g);
    @(posedge clk);
    #1;
    payload_len = l; packet_count = c; gap_cycles = g; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  task automatic wait_beat(input logic [63:0] s, input logic [15:0] i, input string name);
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (axis_if.AXIS_TX_TVALID && axis_if.AXIS_TX_TDATA[63:0] == s && axis_if.AXIS_TX_TDATA[79:64] == i)
        done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  logic         p_lv = 1'b0, p_lr = 1'b0, p_tv = 1'b0, p_tr = 1'b0, p_tl = 1'b0;
  logic [15:0]  p_ld = '0;
  logic [511:0] p_td = '0;
  logic [63:0]  p_tk = '0;

  // Monitor: protocol checks and scoreboard pops on every handshake.
  always @(negedge clk) begin
    if (reset) begin
      p_lv = 1'b0;
      p_tv = 1'b0;
    end else begin
      if (axis_if.AXIS_LEN_TVALID || axis_if.AXIS_TX_TVALID)
        chk("valid_exclusive", 64'(axis_if.AXIS_LEN_TVALID && axis_if.AXIS_TX_TVALID), 64'd0);
      if (p_lv && !p_lr)
        chk("len_hold", {axis_if.AXIS_LEN_TVALID, axis_if.AXIS_LEN_TDATA}, {1'b1, p_ld});
      if (p_tv && !p_tr) begin
        chk("tx_hold_valid", 64'(axis_if.AXIS_TX_TVALID), 64'd1);
        chk("tx_hold_content", 64'(axis_if.AXIS_TX_TDATA == p_td && axis_if.AXIS_TX_TKEEP == p_tk &&
                                    axis_if.AXIS_TX_TLAST == p_tl), 64'd1);
      end
      if (axis_if.AXIS_LEN_TVALID && !p_lv && have_last) begin
        dist_q.push_back(cyc - last_cyc);
        have_last = 1'b0;
      end
      if (axis_if.AXIS_LEN_TVALID && axis_if.AXIS_LEN_TREADY) begin
        if (exp_len.size() == 0) fail_now("len_unexpected");
        else chk("len_tdata", 64'(axis_if.AXIS_LEN_TDATA), 64'(exp_len.pop_front()));
      end
      if (axis_if.AXIS_TX_TVALID && axis_if.AXIS_TX_TREADY) begin
        if (exp_tx.size() == 0) begin
          fail_now("tx_unexpected");
        end else begin
          beat_t e;
          int bad_fill;
          e = exp_tx.pop_front();
          bad_fill = 0;
          for (int k = 10; k < 64; k++)
            if (axis_if.AXIS_TX_TKEEP[k] && axis_if.AXIS_TX_TDATA[8*k +: 8] !== 8'hA5) bad_fill++;
          chk("tx_seq", axis_if.AXIS_TX_TDATA[63:0], e.seq);
          chk("tx_index", 64'(axis_if.AXIS_TX_TDATA[79:64]), 64'(e.idx));
          chk("tx_keep", axis_if.AXIS_TX_TKEEP, e.keep);
          chk("tx_last", 64'(axis_if.AXIS_TX_TLAST), 64'(e.last));
          chk("tx_fill", 64'(bad_fill), 64'd0);
        end
        if (axis_if.AXIS_TX_TLAST) begin
          have_last = 1'b1;
          last_cyc  = cyc;
        end
      end
      p_lv = axis_if.AXIS_LEN_TVALID; p_lr = axis_if.AXIS_LEN_TREADY; p_ld = axis_if.AXIS_LEN_TDATA;
      p_tv = axis_if.AXIS_TX_TVALID;  p_tr = axis_if.AXIS_TX_TREADY;  p_td = axis_if.AXIS_TX_TDATA;
      p_tk = axis_if.AXIS_TX_TKEEP;   p_tl = axis_if.AXIS_TX_TLAST;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_len_valid", 64'(axis_if.AXIS_LEN_TVALID), 64'd0);
    chk("rst_tx_valid", 64'(axis_if.AXIS_TX_TVALID), 64'd0);
    chk("rst_tlast", 64'(axis_if.AXIS_TX_TLAST), 64'd0);
    chk("rst_len_error", 64'(len_error), 64'd0);
    chk("rst_packets_sent", 64'(packets_sent), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // single packet, len=100
    exp_len.push_back(16'd100);
    push_beat(64'd0, 16'd0, '1, 1'b0);
    push_beat(64'd0, 16'd1, 64'h0000_000F_FFFF_FFFF, 1'b1);
    start_run(16'd100, 32'd1, 16'd0);
    wait_idle("single_timeout");
    chk("single_packets_sent", 64'(packets_sent), 64'd1);
    chk("single_drain", 64'(exp_tx.size()), 64'd0);

    // exact multiple with gap=2
    have_last = 1'b0;
    dist_q.delete();
    for (int s = 0; s < 3; s++) begin
      exp_len.push_back(16'd128);
      push_beat(64'(s), 16'd0, '1, 1'b0);
      push_beat(64'(s), 16'd1, '1, 1'b1);
    end
    start_run(16'd128, 32'd3, 16'd2);
    wait_idle("gap_timeout");
    chk("gap_packets_sent", 64'(packets_sent), 64'd3);
    chk("gap_dist_count", 64'(dist_q.size()), 64'd2);
    foreach (dist_q[i]) chk("gap_distance", 64'(dist_q[i]), 64'd3);

    // backpressure, len=1
    for (int s = 0; s < 4; s++) begin
      exp_len.push_back(16'd1);
      push_beat(64'(s), 16'd0, 64'h1, 1'b1);
    end
    rand_rdy = 1'b1;
    start_run(16'd1, 32'd4, 16'd0);
    wait_idle("bp_timeout");
    rand_rdy = 1'b0;
    chk("bp_packets_sent", 64'(packets_sent), 64'd4);

    // stop during packet 4, len=200
    for (int s = 0; s < 5; s++) begin
      exp_len.push_back(16'd200);
      for (int b = 0; b < 3; b++) push_beat(64'(s), 16'(b), '1, 1'b0);
      push_beat(64'(s), 16'd3, 64'hFF, 1'b1);
    end
    start_run(16'd200, 32'd0, 16'd0);
    wait_beat(64'd4, 16'd2, "stop_wait_timeout");
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_idle("stop_timeout");
    chk("stop_packets_sent", 64'(packets_sent), 64'd5);
    chk("stop_drain", 64'(exp_tx.size()), 64'd0);

    // length limits
    start_run(16'd0, 32'd1, 16'd0);
    @(negedge clk);
    chk("len0_error", 64'(len_error), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    exp_len.push_back(16'd8972);
    for (int b = 0; b < 140; b++) push_beat(64'd0, 16'(b), '1, 1'b0);
    push_beat(64'd0, 16'd140, 64'h0000_0000_0000_0FFF, 1'b1);
    start_run(16'd8972, 32'd1, 16'd0);
    chk("max_len_error", 64'(len_error), 64'd0);
    chk("max_busy", 64'(busy), 64'd1);
    wait_idle("max_timeout");
    chk("max_packets_sent", 64'(packets_sent), 64'd1);
    start_run(16'd8973, 32'd1, 16'd0);
    @(negedge clk);
    chk("over_len_error", 64'(len_error), 64'd1);
    chk("over_busy", 64'(busy), 64'd0);

    // reset during beat 1
    exp_len.push_back(16'd200);
    for (int b = 0; b < 3; b++) push_beat(64'd0, 16'(b), '1, 1'b0);
    push_beat(64'd0, 16'd3, 64'hFF, 1'b1);
    start_run(16'd200, 32'd1, 16'd0);
    wait_beat(64'd0, 16'd1, "rst_wait_timeout");
    #2 reset = 1'b1;
    #1;
    chk("midrst_tx_valid", 64'(axis_if.AXIS_TX_TVALID), 64'd0);
    chk("midrst_tlast", 64'(axis_if.AXIS_TX_TLAST), 64'd0);
    chk("midrst_len_valid", 64'(axis_if.AXIS_LEN_TVALID), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_len_error", 64'(len_error), 64'd0);
    exp_len.delete();
    exp_tx.delete();
    have_last = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    exp_len.push_back(16'd100);
    push_beat(64'd0, 16'd0, '1, 1'b0);
    push_beat(64'd0, 16'd1, 64'h0000_000F_FFFF_FFFF, 1'b1);
    start_run(16'd100, 32'd1, 16'd0);
    wait_idle("post_rst_timeout");
    chk("post_rst_packets_sent", 64'(packets_sent), 64'd1);

    chk("final_len_drain", 64'(exp_len.size()), 64'd0);
    chk("final_tx_drain", 64'(exp_tx.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
